// File: rtl/seg_pkg.sv
// Shared types, segment encodings and sizing helpers for the multiplexed
// 7-segment display driver.
package seg_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  // Active-low {g,f,e,d,c,b,a}; A-F rendered as A,b,C,d,E,F.
  function automatic logic [6:0] seg_glyph(input logic [3:0] val);
    case (val)
      4'h0:    seg_glyph = 7'h40;
      4'h1:    seg_glyph = 7'h79;
      4'h2:    seg_glyph = 7'h24;
      4'h3:    seg_glyph = 7'h30;
      4'h4:    seg_glyph = 7'h19;
      4'h5:    seg_glyph = 7'h12;
      4'h6:    seg_glyph = 7'h02;
      4'h7:    seg_glyph = 7'h78;
      4'h8:    seg_glyph = 7'h00;
      4'h9:    seg_glyph = 7'h10;
      4'hA:    seg_glyph = 7'h08;
      4'hB:    seg_glyph = 7'h03;
      4'hC:    seg_glyph = 7'h46;
      4'hD:    seg_glyph = 7'h21;
      4'hE:    seg_glyph = 7'h06;
      default: seg_glyph = 7'h0E;
    endcase
  endfunction

  // Decimal digits needed for 2^dw-1, i.e. floor(dw*log10(2)) + 1.
  function automatic int bcd_digits(input int dw);
    return (dw * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter: one adjust+shift per clock,
// busy for exactly DW cycles after start.
module bin2bcd_seq
  import seg_pkg::*;
#(
  parameter int DW = 16,
  parameter int ND = bcd_digits(DW)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [DW-1:0]   bin,
  output logic            busy,
  output logic            done,
  output logic [4*ND-1:0] bcd
);

  localparam int CW = $clog2(DW + 1);

  logic [DW-1:0]   sh;
  logic [4*ND-1:0] acc;
  logic [4*ND-1:0] adj;
  logic [CW-1:0]   cnt;

  always_comb begin
    adj = acc;
    for (int i = 0; i < ND; i++) begin
      if (acc[4*i +: 4] >= 4'd5) adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh   <= '0;
      acc  <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (busy) begin
      {acc, sh} <= {adj, sh} << 1;
      cnt       <= cnt - CW'(1);
      if (cnt == CW'(1)) busy <= 1'b0;
    end else if (start) begin
      sh   <= bin;
      acc  <= '0;
      cnt  <= CW'(DW);
      busy <= 1'b1;
    end
  end

  // done marks the final shift; bcd holds the finished result from the next cycle on.
  assign done = busy && (cnt == CW'(1));
  assign bcd  = acc;

endmodule

// File: rtl/seg_display_mux.sv
// Multiplexed NDIG-digit common-anode 7-segment driver, hex or decimal display.
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zero digits.
//
//  state | meaning
//  IDLE  | waiting for a load strobe or a pending load
//  CONV  | decimal conversion running in bin2bcd_seq
//  DONE  | new digits/dp/ovf committed to the shadow at the end of this cycle
module seg_display_mux
  import seg_pkg::*;
#(
  parameter int NDIG    = 4,
  parameter int DW      = 16,
  parameter int CLK_HZ  = 50_000_000,
  parameter int SCAN_HZ = 1000
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [DW-1:0]   dat,
  input  logic            dat_vld,
  input  logic            mode,
  input  logic [NDIG-1:0] dp,
  output logic            busy,
  output logic            ovf,
  output logic            ce_ms,
  output logic [NDIG-1:0] AN,
  output logic [7:0]      SEG
);

  localparam int P  = CLK_HZ / SCAN_HZ;
  localparam int PW = (P > 1) ? $clog2(P) : 1;
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int ND = bcd_digits(DW);
  localparam int LW = 4 * NDIG;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic [PW-1:0]   pre_cnt;
  logic [IW-1:0]   idx, idx_nxt;

  state_t          state;
  logic            cap_mode;
  logic [DW-1:0]   cap_dat;
  logic [NDIG-1:0] cap_dp;
  logic            pend, pend_mode;
  logic [DW-1:0]   pend_dat;
  logic [NDIG-1:0] pend_dp;
  logic            go, src_mode;
  logic [DW-1:0]   src_dat;
  logic [NDIG-1:0] src_dp;

  logic            conv_busy, conv_done;
  logic [4*ND-1:0] bcd;

  logic            sh_vld, sh_ovf;
  logic [NDIG-1:0] sh_dp;
  logic [3:0]      sh_dig [NDIG];
  logic [3:0]      nx_dig [NDIG];
  logic            nx_ovf;
  logic [LW-1:0]   dat_x, bcd_x;

  logic [3:0]      cur_dig;
  logic            cur_dp, cur_lead;
  logic [7:0]      seg_nxt;

  assign ce_ms   = (pre_cnt == PW'(P - 1));
  assign idx_nxt = !ce_ms ? idx : (idx == IW'(NDIG - 1)) ? '0 : idx + IW'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_cnt <= '0;
      idx     <= '0;
    end else begin
      pre_cnt <= ce_ms ? '0 : pre_cnt + PW'(1);
      idx     <= idx_nxt;
    end
  end

  // A live strobe in IDLE wins over (and discards) an older pending load.
  assign go       = (state == IDLE) && (dat_vld || pend);
  assign src_mode = dat_vld ? mode : pend_mode;
  assign src_dat  = dat_vld ? dat  : pend_dat;
  assign src_dp   = dat_vld ? dp   : pend_dp;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cap_mode  <= 1'b0;
      cap_dat   <= '0;
      cap_dp    <= '0;
      pend      <= 1'b0;
      pend_mode <= 1'b0;
      pend_dat  <= '0;
      pend_dp   <= '0;
    end else begin
      if (dat_vld && state != IDLE) begin
        pend      <= 1'b1;
        pend_mode <= mode;
        pend_dat  <= dat;
        pend_dp   <= dp;
      end else if (go) begin
        pend <= 1'b0;
      end
      case (state)
        IDLE: if (go) begin
          cap_mode <= src_mode;
          cap_dat  <= src_dat;
          cap_dp   <= src_dp;
          state    <= src_mode ? CONV : DONE;
        end
        CONV:    if (conv_done) state <= DONE;
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  bin2bcd_seq #(.DW(DW), .ND(ND)) u_bcd (
    .clk   (clk),
    .rst_n (rst_n),
    .start (go && src_mode),
    .bin   (src_dat),
    .busy  (conv_busy),
    .done  (conv_done),
    .bcd   (bcd)
  );

  assign busy  = conv_busy;
  assign dat_x = LW'(cap_dat);
  assign bcd_x = LW'(bcd);

  always_comb begin
    nx_ovf = 1'b0;
    for (int i = 0; i < NDIG; i++) nx_dig[i] = cap_mode ? bcd_x[4*i +: 4] : dat_x[4*i +: 4];
    if (cap_mode) begin
      for (int i = NDIG; i < ND; i++) nx_ovf |= (bcd[4*i +: 4] != 4'd0);
    end else begin
      for (int b = LW; b < DW; b++) nx_ovf |= cap_dat[b];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_vld <= 1'b0;
      sh_ovf <= 1'b0;
      sh_dp  <= '0;
      for (int i = 0; i < NDIG; i++) sh_dig[i] <= '0;
    end else if (state == DONE) begin
      sh_vld <= 1'b1;
      sh_ovf <= nx_ovf;
      sh_dp  <= cap_dp;
      for (int i = 0; i < NDIG; i++) sh_dig[i] <= nx_dig[i];
    end
  end

  assign ovf = sh_ovf;

  // Segment data is looked up with the next scan index so SEG and AN switch on the same edge.
  always_comb begin
    cur_dig  = sh_dig[idx_nxt];
    cur_dp   = sh_dp[idx_nxt];
    cur_lead = 1'b1;
    for (int i = 0; i < NDIG; i++) begin
      if (i >= int'(idx_nxt) && sh_dig[i] != 4'd0) cur_lead = 1'b0;
    end
    if (!sh_vld)
      seg_nxt = 8'hFF;
    else if (sh_ovf)
      seg_nxt = {1'b1, SEG_DASH};
    else if (LZB && idx_nxt != '0 && cur_lead && !cur_dp)
      seg_nxt = {1'b1, SEG_BLANK};
    else
      seg_nxt = {~cur_dp, seg_glyph(cur_dig)};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      AN  <= '1;
      SEG <= 8'hFF;
    end else begin
      AN  <= ~(NDIG'(1) << idx_nxt);
      SEG <= seg_nxt;
    end
  end

endmodule
